output_display: RTL

Output-register and display reader for the 8-bit computer's shared bus. On a load strobe it captures the byte the datapath drives onto `bus` and converts it to decimal with a sequential shift-add-3 (double-dabble) engine. It then time-multiplexes the result onto the board's four-digit seven-segment display. It is the consumer on the bus, opposite the blocks that write the bus such as the program counter.

---
 rtl/output_display.sv | 228 ++++++++++++++++++++++
 1 files changed

// File: rtl/output_display.sv
// output_display: output register and decimal display reader for the shared bus.
// A load captures the bus byte. A sequential shift-add-3 engine then converts it
// to BCD over 8 cycles. The result is time-multiplexed onto a 4-digit display.
//
// Ports:
//   clock        system clock, rising edge
//   reset_btn    asynchronous active-low reset
//   bus[7:0]     shared data bus, sampled when load is high
//   load         output-register load strobe
//   signed_mode  1 = captured byte is two's complement (sampled with load)
//   out_value    raw captured byte
//   busy         conversion in progress
//   NEG          displayed value is negative
//   SS_Out[6:0]  active-low segments {g,f,e,d,c,b,a} (combinational decode)
//   SS_Sel[3:0]  active-low one-hot digit select, bit 0 = ones (combinational decode)
//
// Build option: define OUTPUT_DISPLAY_BLANK_EN to enable leading-zero blanking
// of the hundreds and tens digits.

module output_display #(
  parameter int unsigned REFRESH_DIV = 50000
) (
  input  logic       clock,
  input  logic       reset_btn,
  input  logic [7:0] bus,
  input  logic       load,
  input  logic       signed_mode,
  output logic [7:0] out_value,
  output logic       busy,
  output logic       NEG,
  output logic [6:0] SS_Out,
  output logic [3:0] SS_Sel
);

  localparam int unsigned DATA_W = 8;
  localparam int unsigned BCD_W  = 12;
  localparam int unsigned CNT_W  = $clog2(REFRESH_DIV);
  localparam int unsigned SHF_W  = 4;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_MINUS = 7'b0111111;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    CONV = 1'b1
  } state_e;

  state_e state_q, state_d;

  logic [DATA_W-1:0] out_value_q, out_value_d;
  logic              sign_q, sign_d;
  logic [DATA_W-1:0] mag_q, mag_d;
  logic [BCD_W-1:0]  bcd_q, bcd_d;
  logic [SHF_W-1:0]  shift_cnt_q, shift_cnt_d;
  logic [3:0]        disp_hun_q, disp_hun_d;
  logic [3:0]        disp_ten_q, disp_ten_d;
  logic [3:0]        disp_one_q, disp_one_d;
  logic              neg_q, neg_d;
  logic [CNT_W-1:0]  scan_cnt_q, scan_cnt_d;
  logic [1:0]        dig_idx_q, dig_idx_d;

  logic capture_c;
  logic shift_c;
  logic commit_c;

  logic [BCD_W-1:0]        bcd_adj;
  logic [BCD_W+DATA_W-1:0] shifted;

  // State register
  always_ff @(posedge clock or negedge reset_btn) begin
    if (!reset_btn) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: a load always (re)starts, the 8th shift finishes
  always_comb begin
    state_d = state_q;
    if (load) begin
      state_d = CONV;
    end else if (state_q == CONV && shift_cnt_q == SHF_W'(7)) begin
      state_d = IDLE;
    end
  end

  // FSM control outputs
  always_comb begin
    capture_c = 1'b0;
    shift_c   = 1'b0;
    commit_c  = 1'b0;
    if (load) begin
      capture_c = 1'b1;
    end else if (state_q == CONV) begin
      shift_c  = 1'b1;
      commit_c = (shift_cnt_q == SHF_W'(7));
    end
  end

  // Double-dabble step: add 3 to nibbles >= 5, then shift {bcd, mag} left
  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < 3; i++) begin
      if (bcd_q[i*4 +: 4] >= 4'd5) begin
        bcd_adj[i*4 +: 4] = bcd_q[i*4 +: 4] + 4'd3;
      end
    end
    shifted = {bcd_adj, mag_q} << 1;
  end

  // Datapath next-state
  always_comb begin
    out_value_d = out_value_q;
    sign_d      = sign_q;
    mag_d       = mag_q;
    bcd_d       = bcd_q;
    shift_cnt_d = shift_cnt_q;
    disp_hun_d  = disp_hun_q;
    disp_ten_d  = disp_ten_q;
    disp_one_d  = disp_one_q;
    neg_d       = neg_q;
    if (capture_c) begin
      out_value_d = bus;
      sign_d      = signed_mode & bus[7];
      mag_d       = (signed_mode & bus[7]) ? DATA_W'(~bus + 8'd1) : bus;
      bcd_d       = '0;
      shift_cnt_d = '0;
    end else if (shift_c) begin
      bcd_d       = shifted[BCD_W+DATA_W-1:DATA_W];
      mag_d       = shifted[DATA_W-1:0];
      shift_cnt_d = shift_cnt_q + SHF_W'(1);
      // Display only ever takes a finished result
      if (commit_c) begin
        disp_hun_d = shifted[19:16];
        disp_ten_d = shifted[15:12];
        disp_one_d = shifted[11:8];
        neg_d      = sign_q;
      end
    end
  end

  // Free-running digit scan
  always_comb begin
    scan_cnt_d = scan_cnt_q + CNT_W'(1);
    dig_idx_d  = dig_idx_q;
    if (scan_cnt_q == CNT_W'(REFRESH_DIV - 1)) begin
      scan_cnt_d = '0;
      dig_idx_d  = dig_idx_q + 2'd1;
    end
  end

  // Datapath and scan registers
  always_ff @(posedge clock or negedge reset_btn) begin
    if (!reset_btn) begin
      out_value_q <= '0;
      sign_q      <= 1'b0;
      mag_q       <= '0;
      bcd_q       <= '0;
      shift_cnt_q <= '0;
      disp_hun_q  <= '0;
      disp_ten_q  <= '0;
      disp_one_q  <= '0;
      neg_q       <= 1'b0;
      scan_cnt_q  <= '0;
      dig_idx_q   <= '0;
    end else begin
      out_value_q <= out_value_d;
      sign_q      <= sign_d;
      mag_q       <= mag_d;
      bcd_q       <= bcd_d;
      shift_cnt_q <= shift_cnt_d;
      disp_hun_q  <= disp_hun_d;
      disp_ten_q  <= disp_ten_d;
      disp_one_q  <= disp_one_d;
      neg_q       <= neg_d;
      scan_cnt_q  <= scan_cnt_d;
      dig_idx_q   <= dig_idx_d;
    end
  end

  function automatic logic [6:0] seg7(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

  logic hun_blank;
  logic ten_blank;

`ifdef OUTPUT_DISPLAY_BLANK_EN
  assign hun_blank = (disp_hun_q == 4'd0);
  assign ten_blank = (disp_hun_q == 4'd0) && (disp_ten_q == 4'd0);
`else
  assign hun_blank = 1'b0;
  assign ten_blank = 1'b0;
`endif

  // Segment / select decode of the registered digit index
  always_comb begin
    SS_Out = SEG_BLANK;
    case (dig_idx_q)
      2'd0: SS_Out = seg7(disp_one_q);
      2'd1: SS_Out = ten_blank ? SEG_BLANK : seg7(disp_ten_q);
      2'd2: SS_Out = hun_blank ? SEG_BLANK : seg7(disp_hun_q);
      2'd3: SS_Out = neg_q ? SEG_MINUS : SEG_BLANK;
      default: SS_Out = SEG_BLANK;
    endcase
  end

  assign SS_Sel    = ~(4'b0001 << dig_idx_q);
  assign out_value = out_value_q;
  assign busy      = (state_q == CONV);
  assign NEG       = neg_q;

endmodule
